// File: rtl/digit_scan_scheduler.sv
// rtl/digit_scan_scheduler.sv - four-digit scan scheduler with dwell/blank timing and frame-boundary commit
// Shadow digit values are committed to the active set only when the scan wraps, so a frame never mixes old and new values.
module digit_scan_scheduler #(
  parameter int DATA_W       = 8,
  parameter int DWELL_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic [3:0]        i_digit_en,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_dig0,
  input  logic [DATA_W-1:0] i_dig1,
  input  logic [DATA_W-1:0] i_dig2,
  input  logic [DATA_W-1:0] i_dig3,
  output logic              o_pending,
  output logic [1:0]        o_sel,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_frame_done
);

  localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_BLANK} state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [3:0][DATA_W-1:0]   shadow_q, shadow_d;
  logic [3:0][DATA_W-1:0]   active_q, active_d;
  logic [3:0][DATA_W-1:0]   dig_in;
  logic [3:0][DATA_W-1:0]   commit_src;
  logic                     pend_d, valid_d, fd_d;
  logic [1:0]               sel_d, adv_idx, start_idx;
  logic [DATA_W-1:0]        data_d;
  logic                     do_adv, wrap;

  assign dig_in = {i_dig3, i_dig2, i_dig1, i_dig0};

  // First enabled index strictly after cur, wrapping; returns cur when only cur is enabled.
  function automatic logic [1:0] next_idx(input logic [3:0] mask, input logic [1:0] cur);
    logic [1:0] idx;
    idx = cur;
    for (int k = 4; k >= 1; k--) begin
      if (mask[cur + 2'(k)]) idx = cur + 2'(k);
    end
    return idx;
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shadow_d   = shadow_q;
    active_d   = active_q;
    pend_d     = o_pending;
    sel_d      = o_sel;
    data_d     = o_data;
    valid_d    = o_valid;
    fd_d       = 1'b0;
    do_adv     = 1'b0;
    wrap       = 1'b0;
    commit_src = active_q;
    adv_idx    = next_idx(i_digit_en, o_sel);
    start_idx  = next_idx(i_digit_en, 2'd3);

    if (i_load) begin
      shadow_d = dig_in;
      if (state_q == S_IDLE) begin
        active_d = dig_in;
        pend_d   = 1'b0;
      end else begin
        pend_d = 1'b1;
      end
    end

    if (!i_enable) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      sel_d   = '0;
      data_d  = '0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_digit_en != 4'b0) begin
            state_d  = S_ACTIVE;
            cnt_d    = '0;
            active_d = shadow_d;
            pend_d   = 1'b0;
            sel_d    = start_idx;
            data_d   = shadow_d[start_idx];
            valid_d  = 1'b1;
          end
        end
        S_ACTIVE: begin
          if (cnt_q == DWELL_LAST) begin
            if (BLANK_CYCLES == 0) begin
              do_adv = 1'b1;
            end else begin
              state_d = S_BLANK;
              cnt_d   = '0;
              data_d  = '0;
              valid_d = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_BLANK: begin
          if (BLANK_CYCLES == 0 || cnt_q == BLANK_LAST) do_adv = 1'b1;
          else cnt_d = cnt_q + CNT_W'(1);
        end
        default: state_d = S_IDLE;
      endcase
    end

    // An empty mask parks the scan in BLANK; the advance is retried every cycle.
    if (do_adv) begin
      if (i_digit_en == 4'b0) begin
        state_d = S_BLANK;
        data_d  = '0;
        valid_d = 1'b0;
      end else begin
        wrap = (adv_idx <= o_sel);
        if (wrap) begin
          fd_d = 1'b1;
          if (o_pending) begin
            active_d   = shadow_q;
            commit_src = shadow_q;
          end
          if (!i_load) pend_d = 1'b0;
        end
        state_d = S_ACTIVE;
        cnt_d   = '0;
        sel_d   = adv_idx;
        data_d  = commit_src[adv_idx];
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      shadow_q     <= '0;
      active_q     <= '0;
      o_pending    <= 1'b0;
      o_sel        <= '0;
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      o_pending    <= pend_d;
      o_sel        <= sel_d;
      o_data       <= data_d;
      o_valid      <= valid_d;
      o_frame_done <= fd_d;
    end
  end

endmodule

// File: tb/tb_digit_scan_scheduler.sv
// tb/tb_digit_scan_scheduler.sv - bench for digit_scan_scheduler against a slot-timeline reference model
// The model tracks each digit as one slot of DWELL+BLANK cycles rather than an explicit state machine.
module tb_digit_scan_scheduler;

  localparam int DW    = 8;
  localparam int DWELL = 4;
  localparam int BLANK = 2;
  localparam int SLOT  = DWELL + BLANK;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_enable = 1'b0;
  logic [3:0]    i_digit_en = 4'b0;
  logic          i_load = 1'b0;
  logic [DW-1:0] i_dig0 = '0, i_dig1 = '0, i_dig2 = '0, i_dig3 = '0;
  logic          o_pending, o_valid, o_frame_done;
  logic [1:0]    o_sel;
  logic [DW-1:0] o_data;
  logic [12:0]   dut_outs;

  digit_scan_scheduler #(.DATA_W(DW), .DWELL_CYCLES(DWELL), .BLANK_CYCLES(BLANK)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_enable(i_enable), .i_digit_en(i_digit_en),
    .i_load(i_load), .i_dig0(i_dig0), .i_dig1(i_dig1), .i_dig2(i_dig2), .i_dig3(i_dig3),
    .o_pending(o_pending), .o_sel(o_sel), .o_data(o_data), .o_valid(o_valid),
    .o_frame_done(o_frame_done)
  );

  assign dut_outs = {o_sel, o_data, o_valid, o_frame_done, o_pending};

  always #5 i_clk = ~i_clk;

  int compared = 0;
  int mismatched = 0;

  logic          m_run, m_wait, m_fd, m_pend;
  int            m_sel, m_phase;
  logic [DW-1:0] m_shadow [4];
  logic [DW-1:0] m_active [4];

  function automatic logic [12:0] exp_outs();
    logic v;
    v = m_run && !m_wait && (m_phase < DWELL);
    return {2'(m_sel), v ? m_active[m_sel] : 8'h00, v, m_fd, m_pend};
  endfunction

  function automatic int lowest_enabled(input logic [3:0] mask);
    for (int i = 0; i < 4; i++) if (mask[i]) return i;
    return 0;
  endfunction

  function automatic int next_enabled(input logic [3:0] mask, input int cur);
    for (int k = 1; k <= 4; k++) if (mask[(cur + k) % 4]) return (cur + k) % 4;
    return cur;
  endfunction

  task automatic model_reset();
    m_run = 0; m_wait = 0; m_fd = 0; m_pend = 0; m_sel = 0; m_phase = 0;
    for (int i = 0; i < 4; i++) begin m_shadow[i] = '0; m_active[i] = '0; end
  endtask

  task automatic model_step();
    logic [DW-1:0] digs [4];
    logic [DW-1:0] old_sh [4];
    logic old_pend;
    int nxt;
    if (!i_rst_n) begin
      model_reset();
    end else begin
      digs = '{i_dig0, i_dig1, i_dig2, i_dig3};
      old_sh = m_shadow;
      old_pend = m_pend;
      m_fd = 0;
      if (i_load) begin
        m_shadow = digs;
        if (!m_run) begin m_active = digs; m_pend = 0; end
        else m_pend = 1;
      end
      if (!i_enable) begin
        m_run = 0; m_wait = 0; m_sel = 0; m_phase = 0;
      end else if (!m_run) begin
        if (i_digit_en != 0) begin
          m_run = 1; m_wait = 0; m_phase = 0;
          m_sel = lowest_enabled(i_digit_en);
          m_active = m_shadow; m_pend = 0;
        end
      end else if (m_wait || m_phase == SLOT - 1) begin
        if (i_digit_en == 0) begin
          m_wait = 1;
        end else begin
          nxt = next_enabled(i_digit_en, m_sel);
          if (nxt <= m_sel) begin
            m_fd = 1;
            if (old_pend) m_active = old_sh;
            if (!i_load) m_pend = 0;
          end
          m_sel = nxt; m_phase = 0; m_wait = 0;
        end
      end else begin
        m_phase++;
      end
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    model_step();
    @(negedge i_clk);
  endtask

  task automatic set_digs(input logic [DW-1:0] a, b, c, d);
    i_dig0 = a; i_dig1 = b; i_dig2 = c; i_dig3 = d;
  endtask

  task automatic test_reset();
    model_reset();
    i_rst_n = 0;
    tick(); tick();
    compared++;
    if (dut_outs !== 13'h0) begin
      mismatched++; $display("FAIL reset_outs: got %h expected %h", dut_outs, 13'h0);
    end
    i_rst_n = 1;
    tick();
    compared++;
    if (dut_outs !== exp_outs()) begin
      mismatched++; $display("FAIL reset_idle: got %h expected %h", dut_outs, exp_outs());
    end
  endtask

  task automatic test_full_scan();
    int fd_cnt = 0;
    i_digit_en = 4'b1111;
    set_digs(8'h11, 8'h22, 8'h33, 8'h44);
    i_load = 1; tick(); i_load = 0;
    compared++;
    if (dut_outs !== exp_outs()) begin
      mismatched++; $display("FAIL idle_load: got %h expected %h", dut_outs, exp_outs());
    end
    i_enable = 1;
    for (int c = 1; c <= 50; c++) begin
      tick();
      fd_cnt += int'(o_frame_done);
      compared++;
      if (dut_outs !== exp_outs()) begin
        mismatched++; $display("FAIL full_scan c%0d: got %h expected %h", c, dut_outs, exp_outs());
      end
      if (c == 1 || c == 7 || c == 25) begin
        compared++;
        if (!o_valid || o_sel !== 2'((c - 1) / SLOT % 4) || o_data !== 8'((((c - 1) / SLOT % 4) + 1) * 8'h11)) begin
          mismatched++; $display("FAIL full_scan_digit c%0d: got sel %0d data %h valid %b", c, o_sel, o_data, o_valid);
        end
      end
    end
    compared++;
    if (fd_cnt != 2) begin
      mismatched++; $display("FAIL full_scan_frames: got %0d expected 2", fd_cnt);
    end
  endtask

  task automatic test_mask_0101();
    logic found = 0;
    int fd_cnt = 0;
    i_digit_en = 4'b0101;
    for (int c = 0; c < 60 && !found; c++) begin
      tick();
      compared++;
      if (dut_outs !== exp_outs()) begin
        mismatched++; $display("FAIL mask0101_wait: got %h expected %h", dut_outs, exp_outs());
      end
      if (o_frame_done) found = 1;
    end
    compared++;
    if (!found) begin mismatched++; $display("FAIL mask0101_timeout: got no frame_done expected one"); end
    for (int c = 1; c <= 24; c++) begin
      tick();
      fd_cnt += int'(o_frame_done);
      compared++;
      if (dut_outs !== exp_outs() || (o_valid && o_sel[0])) begin
        mismatched++; $display("FAIL mask0101 c%0d: got %h expected %h", c, dut_outs, exp_outs());
      end
    end
    compared++;
    if (fd_cnt != 2) begin mismatched++; $display("FAIL mask0101_period: got %0d frames expected 2", fd_cnt); end
  endtask

  task automatic test_load_midframe();
    logic found;
    i_digit_en = 4'b1111;
    for (int step = 0; step < 3; step++) begin
      found = 0;
      for (int c = 0; c < 60 && !found; c++) begin
        tick();
        compared++;
        if (dut_outs !== exp_outs()) begin
          mismatched++; $display("FAIL midload_wait%0d: got %h expected %h", step, dut_outs, exp_outs());
        end
        if (step == 0) found = o_valid && o_sel == 2'd1;
        else if (step == 1) found = o_valid && o_sel == 2'd2;
        else found = o_frame_done;
      end
      compared++;
      if (!found) begin mismatched++; $display("FAIL midload_timeout%0d: got none expected event", step); end
      if (step == 0) begin
        set_digs(8'hAA, 8'hBB, 8'hCC, 8'hDD);
        i_load = 1; tick(); i_load = 0;
        compared++;
        if (o_pending !== 1'b1 || dut_outs !== exp_outs()) begin
          mismatched++; $display("FAIL midload_pending: got %h expected %h", dut_outs, exp_outs());
        end
      end else if (step == 1) begin
        compared++;
        if (o_data !== 8'h33) begin mismatched++; $display("FAIL midload_sel2_old: got %h expected 33", o_data); end
      end else begin
        compared++;
        if (o_data !== 8'hAA || o_sel !== 2'd0 || o_pending !== 1'b0) begin
          mismatched++; $display("FAIL midload_commit: got sel %0d data %h pend %b expected 0 aa 0", o_sel, o_data, o_pending);
        end
      end
    end
  endtask

  task automatic test_mask_zero();
    int vcnt = 0;
    i_digit_en = 4'b0000;
    for (int c = 1; c <= 12; c++) begin
      tick();
      vcnt += int'(o_valid);
      compared++;
      if (dut_outs !== exp_outs() || (c >= 6 && (o_valid || o_frame_done))) begin
        mismatched++; $display("FAIL mask_zero c%0d: got %h expected %h", c, dut_outs, exp_outs());
      end
    end
    compared++;
    if (vcnt != 3) begin mismatched++; $display("FAIL mask_zero_dwell: got %0d expected 3", vcnt); end
    i_digit_en = 4'b0010;
    tick();
    compared++;
    if (dut_outs !== exp_outs() || o_sel !== 2'd1 || !o_valid || o_frame_done || o_data !== 8'hBB) begin
      mismatched++; $display("FAIL mask_resume: got %h expected %h", dut_outs, exp_outs());
    end
  endtask

  task automatic test_async_reset();
    #2 i_rst_n = 0;
    #1;
    compared++;
    if ({o_sel, o_data, o_valid} !== 11'h0) begin
      mismatched++; $display("FAIL async_reset: got sel %0d data %h valid %b expected 0", o_sel, o_data, o_valid);
    end
    model_reset();
    tick();
    i_rst_n = 1; i_enable = 0;
    tick();
    compared++;
    if (dut_outs !== exp_outs()) begin
      mismatched++; $display("FAIL after_reset_idle: got %h expected %h", dut_outs, exp_outs());
    end
    i_enable = 1;
    tick();
    compared++;
    if (dut_outs !== exp_outs() || o_data !== 8'h00 || o_sel !== 2'd1 || !o_valid) begin
      mismatched++; $display("FAIL after_reset_restart: got %h expected %h", dut_outs, exp_outs());
    end
  endtask

  task automatic test_enable_drop();
    logic found;
    int vcnt = 0;
    i_enable = 0;
    tick();
    set_digs(8'h11, 8'h22, 8'h33, 8'h44);
    i_load = 1; tick(); i_load = 0;
    i_digit_en = 4'b1111; i_enable = 1;
    for (int step = 0; step < 2; step++) begin
      found = 0;
      for (int c = 0; c < 40 && !found; c++) begin
        tick();
        compared++;
        if (dut_outs !== exp_outs()) begin
          mismatched++; $display("FAIL en_drop_wait%0d: got %h expected %h", step, dut_outs, exp_outs());
        end
        found = (step == 0) ? o_valid : !o_valid;
      end
      compared++;
      if (!found) begin mismatched++; $display("FAIL en_drop_timeout%0d: got none expected event", step); end
      if (step == 0) begin
        set_digs(8'h55, 8'h66, 8'h77, 8'h88);
        i_load = 1; tick(); i_load = 0;
      end
    end
    i_enable = 0;
    tick();
    compared++;
    if (dut_outs !== 13'h001 || dut_outs !== exp_outs()) begin
      mismatched++; $display("FAIL en_drop_idle: got %h expected %h", dut_outs, exp_outs());
    end
    tick();
    i_enable = 1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      vcnt += int'(o_valid);
      compared++;
      if (dut_outs !== exp_outs() || (c == 1 && (o_sel !== 2'd0 || o_data !== 8'h55))) begin
        mismatched++; $display("FAIL en_restart c%0d: got %h expected %h", c, dut_outs, exp_outs());
      end
    end
    compared++;
    if (vcnt != DWELL) begin mismatched++; $display("FAIL en_restart_dwell: got %0d expected %0d", vcnt, DWELL); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      i_enable = ($urandom_range(0, 49) != 0);
      if ($urandom_range(0, 19) == 0) i_digit_en = 4'($urandom);
      i_load = ($urandom_range(0, 9) == 0);
      set_digs(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      tick();
      compared++;
      if (dut_outs !== exp_outs()) begin
        mismatched++; $display("FAIL random c%0d: got %h expected %h", c, dut_outs, exp_outs());
      end
    end
    i_load = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_scan();
    test_mask_0101();
    test_load_midframe();
    test_mask_zero();
    test_async_reset();
    test_enable_drop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
